// File: rtl/chacha_block_serialiser.sv
// Serialises one 512-bit ChaCha20 state matrix into 64 little-endian keystream bytes.
// Optional block counter and busy flag are enabled by defining CHACHA_SER_BLKCNT_EN.
module chacha_block_serialiser #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned NO_WORDS  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [32*NO_WORDS-1:0]  block_in,
  input  logic                    block_valid,
  output logic                    block_ready,
  output logic [DATA_SIZE-1:0]    input_data_split,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    byte_last
`ifdef CHACHA_SER_BLKCNT_EN
  ,
  output logic [31:0]             blocks_done,
  output logic                    ser_busy
`endif
);

  localparam int unsigned NBYTES = NO_WORDS * 4;
  localparam int unsigned IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                               state;
  logic [IDX_W-1:0]                     idx;
  logic [NBYTES-1:0][DATA_SIZE-1:0]     hold;

  logic             byte_xfer;
  logic             last_xfer;
  logic             accept;
  logic [IDX_W-1:0] idx_nxt;

  assign byte_xfer = byte_valid && byte_ready;
  assign last_xfer = byte_xfer && byte_last;
  assign idx_nxt   = idx + 1'b1;

  // Ready is combinational so a new matrix can land on the last-byte cycle without a bubble.
  assign block_ready = !rst && ((state == IDLE) || last_xfer);
  assign accept      = block_valid && block_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      hold             <= '0;
      byte_valid       <= 1'b0;
      byte_last        <= 1'b0;
      input_data_split <= '0;
    end else if (accept) begin
      // Covers both IDLE capture and the zero-bubble reload after byte 63.
      state            <= SHIFT;
      idx              <= '0;
      hold             <= block_in;
      byte_valid       <= 1'b1;
      byte_last        <= (LAST_IDX == '0);
      input_data_split <= block_in[DATA_SIZE-1:0];
    end else if (last_xfer) begin
      state            <= IDLE;
      idx              <= '0;
      byte_valid       <= 1'b0;
      byte_last        <= 1'b0;
      input_data_split <= '0;
    end else if (byte_xfer) begin
      idx              <= idx_nxt;
      byte_last        <= (idx_nxt == LAST_IDX);
      input_data_split <= hold[idx_nxt];
    end
  end

`ifdef CHACHA_SER_BLKCNT_EN
  // Completed-block counter; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      blocks_done <= '0;
    end else if (last_xfer) begin
      blocks_done <= blocks_done + 32'd1;
    end
  end

  assign ser_busy = (state == SHIFT);
`endif

endmodule

// File: tb/tb_chacha_block_serialiser.sv
// Directed scoreboard bench for chacha_block_serialiser (also covers CHACHA_SER_BLKCNT_EN when defined).
module tb_chacha_block_serialiser;

  logic         clk;
  logic         rst;
  logic [511:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic [7:0]   input_data_split;
  logic         byte_valid;
  logic         byte_ready;
  logic         byte_last;
`ifdef CHACHA_SER_BLKCNT_EN
  logic [31:0]  blocks_done;
  logic         ser_busy;
`endif

  chacha_block_serialiser #(.DATA_SIZE(8), .NO_WORDS(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .block_in         (block_in),
    .block_valid      (block_valid),
    .block_ready      (block_ready),
    .input_data_split (input_data_split),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .byte_last        (byte_last)
`ifdef CHACHA_SER_BLKCNT_EN
    ,
    .blocks_done      (blocks_done),
    .ser_busy         (ser_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_xfer   = 0;
  logic       acc;
  logic [8:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected stream: byte b of the matrix is bits [8b+7:8b], last flag on byte 63.
  task automatic push_block(input logic [511:0] blk);
    for (int b = 0; b < 64; b++) sb.push_back({b == 63, blk[8*b +: 8]});
  endtask

  // One clock: sample at the falling edge, score any transfer, return 1 unit after the rising edge.
  task automatic step();
    logic [8:0] exp;
    @(negedge clk);
    if (!rst && byte_valid && byte_ready) begin
      n_xfer++;
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("byte", {23'd0, byte_last, input_data_split}, {23'd0, exp});
      end
    end
    acc = block_valid && block_ready;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] pattern_block();
    logic [511:0] blk;
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = 32'h03020100 + 32'h04040404 * 32'(i);
    return blk;
  endfunction

  function automatic logic [511:0] random_block();
    logic [511:0] blk;
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
    return blk;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x0;
    int nrdy;
    logic [511:0] blk;

    rst = 1'b1; block_valid = 1'b0; block_in = '0; byte_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_block_ready", 32'(block_ready), 32'd0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_last", 32'(byte_last), 32'd0);
    chk("rst_data", 32'(input_data_split), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("ready_after_rst", 32'(block_ready), 32'd1);
`ifdef CHACHA_SER_BLKCNT_EN
    chk("rst_blocks_done", blocks_done, 32'd0);
    chk("rst_ser_busy", 32'(ser_busy), 32'd0);
`endif

    // Single block at full rate.
    blk = pattern_block();
    block_in = blk; block_valid = 1'b1; push_block(blk);
    step();
    chk("t1_accept", 32'(acc), 32'd1);
    block_valid = 1'b0;
    chk("t1_first_valid", 32'(byte_valid), 32'd1);
    chk("t1_first_byte", 32'(input_data_split), 32'h00);
`ifdef CHACHA_SER_BLKCNT_EN
    chk("t1_ser_busy", 32'(ser_busy), 32'd1);
`endif
    x0 = n_xfer;
    repeat (64) step();
    chk("t1_throughput", 32'(n_xfer - x0), 32'd64);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    chk("t1_idle_valid", 32'(byte_valid), 32'd0);
    chk("t1_idle_ready", 32'(block_ready), 32'd1);
`ifdef CHACHA_SER_BLKCNT_EN
    chk("t1_blocks_done", blocks_done, 32'd1);
    chk("t1_ser_idle", 32'(ser_busy), 32'd0);
`endif

    // Backpressure on byte 0x10, with a different matrix offered while not ready.
    block_in = blk; block_valid = 1'b1; push_block(blk);
    step();
    block_valid = 1'b0;
    x0 = n_xfer;
    repeat (16) step();
    chk("t2_pre_stall_byte", 32'(input_data_split), 32'h10);
    byte_ready = 1'b0;
    block_in = random_block(); block_valid = 1'b1;
    repeat (5) begin
      step();
      chk("t2_hold", {22'd0, byte_valid, byte_last, input_data_split}, {22'd0, 1'b1, 1'b0, 8'h10});
      chk("t2_no_accept", 32'(acc), 32'd0);
    end
    block_valid = 1'b0; byte_ready = 1'b1;
    repeat (48) step();
    chk("t2_total_bytes", 32'(n_xfer - x0), 32'd64);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    chk("t2_idle_valid", 32'(byte_valid), 32'd0);
`ifdef CHACHA_SER_BLKCNT_EN
    chk("t2_blocks_done", blocks_done, 32'd2);
`endif

    // Back-to-back blocks with block_valid held high.
    block_in = {64{8'hAA}}; block_valid = 1'b1; push_block({64{8'hAA}});
    step();
    chk("t3_accept_a", 32'(acc), 32'd1);
    block_in = {64{8'hBB}}; push_block({64{8'hBB}});
    x0 = n_xfer; nrdy = 0;
    repeat (64) begin
      step();
      nrdy += int'(acc);
    end
    chk("t3_ready_pulses", 32'(nrdy), 32'd1);
    chk("t3_ready_on_last", 32'(acc), 32'd1);
    chk("t3_b_first", {23'd0, byte_valid, input_data_split}, {23'd0, 1'b1, 8'hBB});
    block_valid = 1'b0;
    repeat (64) step();
    chk("t3_throughput", 32'(n_xfer - x0), 32'd128);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    chk("t3_idle_valid", 32'(byte_valid), 32'd0);
`ifdef CHACHA_SER_BLKCNT_EN
    chk("t3_blocks_done", blocks_done, 32'd4);
`endif

    // Mid-block reset after byte 20.
    block_in = blk; block_valid = 1'b1; push_block(blk);
    step();
    block_valid = 1'b0;
    repeat (21) step();
    chk("t4_pre_rst_byte", 32'(input_data_split), 32'd21);
    rst = 1'b1; #1;
    chk("t4_rst_ready", 32'(block_ready), 32'd0);
    step();
    sb.delete();
    rst = 1'b0; #1;
    chk("t4_valid", 32'(byte_valid), 32'd0);
    chk("t4_last", 32'(byte_last), 32'd0);
    chk("t4_data", 32'(input_data_split), 32'd0);
    chk("t4_ready", 32'(block_ready), 32'd1);
`ifdef CHACHA_SER_BLKCNT_EN
    chk("t4_blocks_done", blocks_done, 32'd0);
    chk("t4_ser_busy", 32'(ser_busy), 32'd0);
`endif

    // Reset coincident with an offered matrix: nothing captured.
    rst = 1'b1; block_in = blk; block_valid = 1'b1;
    step();
    rst = 1'b0; block_valid = 1'b0;
    step();
    chk("t5_no_capture", 32'(byte_valid), 32'd0);

    // Fresh block after reset starts at its byte 0.
    blk = random_block();
    block_in = blk; block_valid = 1'b1; push_block(blk);
    step();
    block_valid = 1'b0;
    chk("t6_first_byte", 32'(input_data_split), 32'(blk[7:0]));
    x0 = n_xfer;
    repeat (64) step();
    chk("t6_throughput", 32'(n_xfer - x0), 32'd64);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);
    chk("t6_idle_ready", 32'(block_ready), 32'd1);
`ifdef CHACHA_SER_BLKCNT_EN
    chk("t6_blocks_done", blocks_done, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chacha_block_serialiser.md
# chacha_block_serialiser

Upstream neighbour of the byte-wide keystream buffer. It accepts one 512-bit ChaCha20 state matrix (16 × 32-bit words) from the block function through a valid/ready handshake. It emits the matrix as 64 sequential bytes in RFC 8439 little-endian order through a second valid/ready handshake. Its byte output feeds the buffer's `input_data_split` port.

## Interface
- `DATA_SIZE`, 8: output byte width; only 8 is supported.
- `NO_WORDS`, 16: words per state matrix; byte count per block = `NO_WORDS*4`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `block_in`  in  `32*NO_WORDS`  state matrix; word *i* at bits `[32i+31:32i]`.
- `block_valid`  in  1  `block_in` is valid.
- `block_ready`  out  1  serialiser can accept a matrix this cycle.
- `input_data_split`  out  `DATA_SIZE`  current keystream byte.
- `byte_valid`  out  1  `input_data_split` is valid.
- `byte_ready`  in  1  downstream accepts the byte this cycle.
- `byte_last`  out  1  current byte is byte 63 of the block.

## Operation
- Block-side handshake: a matrix is accepted when `block_valid && block_ready`. Byte-side handshake: a byte transfers when `byte_valid && byte_ready`.
- States:
  - IDLE: `byte_valid=0`, `block_ready=1`.
  - SHIFT: `byte_valid=1`.
- IDLE→SHIFT on accept.
  - `block_in` is captured into a 512-bit holding register.
  - The 6-bit byte index `idx` is cleared to 0.
- In SHIFT:
  - `input_data_split = hold[8*idx +: 8]`. Byte 0 is word 0 bits `[7:0]`, byte 3 is word 0 bits `[31:24]`, byte 4 is word 1 bits `[7:0]`, and so on.
  - `byte_last = (idx == NO_WORDS*4-1)`.
- On each byte transfer that is not last: `idx <= idx+1`.
- On a last-byte transfer:
  - If `block_valid=1`: capture the new matrix, set `idx <= 0` and remain in SHIFT (zero-bubble back-to-back).
  - Otherwise go to IDLE.
- `block_ready = !rst && (state==IDLE || (byte_valid && byte_ready && byte_last))`. This is combinational from `byte_ready`, and the downstream must not make `byte_ready` depend on `block_ready`.
- Backpressure: while `byte_valid && !byte_ready`, the following hold unchanged:
  - `input_data_split`
  - `byte_last`
  - `idx`
  - the holding register
- Once asserted, `byte_valid` does not drop until a transfer occurs.
- `block_in` is ignored whenever `block_ready=0`. A matrix is never overwritten mid-block.
- `idx` never exceeds 63. Wrap to 0 happens only on a last-byte transfer.

## Timing
- Reset values, registered on the `rst` edge:
  - state = IDLE, `idx` = 0, holding register = 0
  - `byte_valid` = 0, `byte_last` = 0, `input_data_split` = 0
- `block_ready` = 0 while `rst` is high, and 1 on the first cycle after.
- Latency: a matrix accepted at edge N presents byte 0 with `byte_valid=1` after edge N.
- Throughput: 64 bytes in 64 consecutive cycles with `byte_ready` held at 1. Back-to-back blocks produce no idle cycle between byte 63 and the next byte 0.
- `rst` asserted mid-block: the block is discarded and the outputs return to reset values on that edge. No partial completion and no `byte_last`.
- Simultaneous `rst` and accept: `rst` wins and the matrix is not captured.
- All outputs except `block_ready` are registered.

## Configuration
- `CHACHA_SER_BLKCNT_EN`
- Defined:
  - Adds output `blocks_done` (32 bits, reset 0).
  - `blocks_done` increments by 1 on every last-byte transfer and wraps 0xFFFFFFFF→0.
  - Adds output `ser_busy`, which equals `state==SHIFT`.
- Undefined:
  - Neither port exists.
  - No counter logic is synthesised.
  - Byte-path behaviour is identical in both builds.

## Test plan
- Single block: `block_in` word *i* = `0x03020100 + 0x04040404*i`, `byte_ready=1` → bytes 0x00,0x01,…,0x3F on 64 consecutive cycles, starting the cycle after accept. `byte_last=1` only on 0x3F. IDLE afterwards with `block_ready=1`.
- Backpressure: same block, `byte_ready` low for 5 cycles while byte 0x10 is presented → 0x10 is held stable for all 5 cycles, then the sequence resumes at 0x11. Total bytes = 64, no duplicates or drops.
- Back-to-back: block A (all bytes 0xAA) then block B (all 0xBB), with `block_valid` held 1 → `block_ready` pulses on A's last-byte cycle. The first 0xBB appears on the very next cycle: 128 bytes in 128 cycles.
- Mid-block reset: `rst` asserted for one cycle after byte 20 of a block → next cycle `byte_valid=0`, `idx=0`, `block_ready=1`. A new block then starts at its byte 0.
- Ignored input: change `block_in` while `block_ready=0` mid-block → output bytes still match the originally captured matrix.
- With `CHACHA_SER_BLKCNT_EN`: 3 blocks serialised → `blocks_done=3`. `ser_busy` is 0 after the last byte when no further block is pending. Reset returns `blocks_done` to 0.
